mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory request port between the instruction bus (fetch stage) and the data bus (memory stage).
//  Serialises transactions: one outstanding access at a time.
//  Routes each response and its handshake pulses back to the winning requester.
//  Sits between the core's ibus/dbus and the single downstream memory/cache port.
// PARAMETERS
//  ADDR_W        64  address width, both buses
//  DATA_W        64  memory data width; ibus returns 32-bit slice
//  STARVE_LIMIT  4   consecutive dbus grants with ibus pending before ibus is forced (fixed-priority mode)
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-high
//  ireq_valid    in   1       fetch request; held stable until idata_ok
//  ireq_addr     in   ADDR_W  fetch address, 4-byte aligned
//  iaddr_ok      out  1       one-cycle pulse: ibus request accepted
//  idata_ok      out  1       one-cycle pulse: idata valid
//  idata         out  32      instruction word
//  dreq_valid    in   1       data request; held stable until ddata_ok
//  dreq_addr     in   ADDR_W  data address
//  dreq_size     in   3       log2 bytes (0..3)
//  dreq_strobe   in   8       byte write mask; 0 = read
//  dreq_data     in   DATA_W  write data
//  daddr_ok      out  1       one-cycle pulse: dbus request accepted
//  ddata_ok      out  1       one-cycle pulse: ddata valid / write done
//  ddata         out  DATA_W  read data
//  mreq_valid    out  1       downstream request valid
//  mreq_write    out  1       1 = write (strobe != 0)
//  mreq_addr     out  ADDR_W  downstream address
//  mreq_size     out  3       downstream size; ibus transactions use 3'd2
//  mreq_strobe   out  8       downstream strobe; 0 for ibus
//  mreq_data     out  DATA_W  downstream write data
//  mreq_ready    in   1       downstream accepts request this cycle
//  mresp_valid   in   1       downstream response valid (one cycle)
//  mresp_data    in   DATA_W  downstream response data
// BEHAVIOUR
//  Reset (async): state=IDLE, owner=none, starve_cnt=0.
//   All outputs 0, including mreq_valid, which drops immediately.
//   Downstream tolerates an abandoned request.
//  FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
//  IDLE:
//   - pick a winner among valid requesters.
//   - latch addr/size/strobe/data into internal registers.
//   - pulse the winner's *addr_ok in the same cycle.
//   - go to REQ.
//   - no requester valid: stay in IDLE.
//  REQ: mreq_valid=1 with latched fields; on mreq_ready go to WAIT. Fields stay stable while ready is low.
//  WAIT: on mresp_valid, register mresp_data and go to DONE. mresp_valid in any other state is ignored.
//  DONE: pulse winner's *data_ok for exactly one cycle with the registered data, then go to IDLE.
//   A new grant is possible on the following cycle only.
//  Minimum latency, request valid -> data_ok: 3 cycles (IDLE, REQ with ready=1, WAIT with resp, DONE).
//  idata = addr[2] ? rdata[63:32] : rdata[31:0], using the latched address.
//  ddata = full rdata; no sign or extension here.
//  Fixed priority (default): dbus wins when both are valid.
//   - starve_cnt increments on each dbus grant while ireq_valid=1.
//   - starve_cnt clears on any ibus grant or when ireq_valid=0.
//   - when starve_cnt==STARVE_LIMIT and ireq_valid=1: ibus wins.
//   - the counter saturates at STARVE_LIMIT.
//  Simultaneous events:
//   - a new request arriving during REQ/WAIT/DONE is not granted until IDLE.
//   - the loser's valid stays pending; no ok pulse goes to the loser.
//  Requester drops valid mid-transaction: the transaction still completes downstream.
//   data_ok still pulses in DONE; the requester ignores it. No abort path.
//  Only one *addr_ok and one *data_ok are asserted in any cycle.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//   - a 1-bit last_owner register (reset 0 = ibus) gives priority to the bus that did not win last.
//   - starve_cnt is not instantiated.
//   - STARVE_LIMIT is unused.
//  ARB_ROUND_ROBIN_EN undefined: fixed dbus priority with the starvation limit described above.
// TESTING
//  1. Reset mid-WAIT: assert reset with mreq_valid=1.
//     -> all outputs 0 the same cycle. After release the FSM is in IDLE and a new ibus request is granted.
//  2. ibus only: ireq addr=0x8000_0004, mresp_data=0x1111_2222_3333_4444, ready=1.
//     -> iaddr_ok at cycle 0, idata_ok at cycle 3, idata=0x1111_2222.
//  3. Both valid, fixed mode, dreq write addr=0x100, strobe=0xFF.
//     -> dbus granted first: mreq_write=1, mreq_strobe=0xFF.
//     -> ibus granted on the next IDLE: mreq_strobe=0, mreq_size=2.
//  4. Starvation, fixed mode, STARVE_LIMIT=4: dreq_valid and ireq_valid held high.
//     -> the 5th grant goes to ibus, then dbus again.
//  5. Backpressure: mreq_ready low for 5 cycles.
//     -> mreq fields stable, no ok pulses, data_ok arrives 5 cycles later than in scenario 2.
//  6. ARB_ROUND_ROBIN_EN, both held valid for 4 transactions.
//     -> grant order dbus, ibus, dbus, ibus (last_owner reset = ibus).

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one memory port between ibus and dbus, one access outstanding at a time.
// Build option ARB_ROUND_ROBIN_EN: alternate priority instead of dbus-first with a starvation limit.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iaddr_ok,
  output logic              idata_ok,
  output logic [31:0]       idata,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_data,
  output logic              daddr_ok,
  output logic              ddata_ok,
  output logic [DATA_W-1:0] ddata,
  output logic              mreq_valid,
  output logic              mreq_write,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [2:0]        mreq_size,
  output logic [7:0]        mreq_strobe,
  output logic [DATA_W-1:0] mreq_data,
  input  logic              mreq_ready,
  input  logic              mresp_valid,
  input  logic [DATA_W-1:0] mresp_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;  // 1 = dbus owns the transaction
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [7:0]        strobe_q, strobe_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant;
  logic              win_dbus;

  // Grant is masked by reset so no addr_ok escapes while reset is held.
  assign grant = (state_q == S_IDLE) & (ireq_valid | dreq_valid) & ~reset;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q;

  assign win_dbus = dreq_valid & (~ireq_valid | ~last_owner_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      last_owner_q <= 1'b0;
    else if (grant) last_owner_q <= win_dbus;
  end
`else
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign win_dbus = dreq_valid & (~ireq_valid | (starve_q != LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!ireq_valid) begin
      starve_d = '0;
    end else if (grant) begin
      if (!win_dbus)              starve_d = '0;
      else if (starve_q != LIMIT) starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_REQ;
          owner_d = win_dbus;
          if (win_dbus) begin
            addr_d   = dreq_addr;
            size_d   = dreq_size;
            strobe_d = dreq_strobe;
            wdata_d  = dreq_data;
          end else begin
            addr_d   = ireq_addr;
            size_d   = 3'd2;
            strobe_d = '0;
            wdata_d  = '0;
          end
        end
      end
      S_REQ:  if (mreq_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (mresp_valid) begin
          rdata_d = mresp_data;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign iaddr_ok    = grant & ~win_dbus;
  assign daddr_ok    = grant & win_dbus;
  assign idata_ok    = (state_q == S_DONE) & ~owner_q;
  assign ddata_ok    = (state_q == S_DONE) & owner_q;
  assign idata       = addr_q[2] ? rdata_q[32 +: 32] : rdata_q[31:0];
  assign ddata       = rdata_q;
  assign mreq_valid  = (state_q == S_REQ);
  assign mreq_write  = |strobe_q;
  assign mreq_addr   = addr_q;
  assign mreq_size   = size_q;
  assign mreq_strobe = strobe_q;
  assign mreq_data   = wdata_q;

endmodule
`default_nettype wire
